// File: rtl/tohost_status_monitor_if.sv
// Store-snoop channel between a core's memory write port and the tohost monitor.
// The monitor only observes, so there is no ready/backpressure signal.
interface tohost_status_monitor_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
);
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data);
    modport slave  (input  wr_valid, input  wr_addr, input  wr_data);
endinterface

// File: rtl/tohost_status_monitor.sv
// Per-core tohost completion monitor: decodes stores to the tohost word into sticky
// pass/fail status, runs a saturating run-cycle counter and a watchdog.
// Optional build macro TOHOST_SYSCALL_COUNT_EN adds syscall_count/syscall_pulse for
// even, non-zero tohost writes.
module tohost_status_monitor #(
    parameter int unsigned       ADDR_W         = 32,
    parameter int unsigned       DATA_W         = 64,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(32'h8000_1000),
    parameter int unsigned       TIMEOUT_CYCLES = 1000000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           core_reset,
    input  logic                           check_to_host,
    tohost_status_monitor_if.slave         wr,
    input  logic                           status_ack,
    output logic                           pass_status,
    output logic                           fail_status,
    output logic                           timeout,
    output logic [31:0]                    fail_code,
    output logic                           done_pulse,
`ifdef TOHOST_SYSCALL_COUNT_EN
    output logic [15:0]                    syscall_count,
    output logic                           syscall_pulse,
`endif
    output logic [31:0]                    cycle_count
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StRun  = 3'd1;
    localparam logic [2:0] StPass = 3'd2;
    localparam logic [2:0] StFail = 3'd3;
    localparam logic [2:0] StTmo  = 3'd4;

    // Count value at the edge on which the watchdog fires (unused when disabled).
    localparam logic [31:0] TmoLast = 32'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic        pass_q, pass_d;
    logic        fail_q, fail_d;
    logic        tmo_q, tmo_d;
    logic [31:0] fail_code_q, fail_code_d;
    logic        done_q, done_d;
    logic [31:0] cycle_q, cycle_d;
`ifdef TOHOST_SYSCALL_COUNT_EN
    logic [15:0] sys_cnt_q, sys_cnt_d;
    logic        sys_pulse_q, sys_pulse_d;
`endif

    logic hit, hit_odd, hit_pass, wd_fire;

    assign hit      = wr.wr_valid && (wr.wr_addr == TOHOST_ADDR) && check_to_host;
    assign hit_odd  = hit && wr.wr_data[0];
    assign hit_pass = hit && (wr.wr_data == DATA_W'(1));
    assign wd_fire  = (TIMEOUT_CYCLES != 0) && (cycle_q == TmoLast);

    // Next-state: hit beats watchdog; core_reset in RUN beats both.
    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        tmo_d       = tmo_q;
        fail_code_d = fail_code_q;
        done_d      = 1'b0;
        cycle_d     = cycle_q;
`ifdef TOHOST_SYSCALL_COUNT_EN
        sys_cnt_d   = sys_cnt_q;
        sys_pulse_d = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (!core_reset) begin
                    state_d     = StRun;
                    cycle_d     = '0;
                    fail_code_d = '0;
`ifdef TOHOST_SYSCALL_COUNT_EN
                    sys_cnt_d   = '0;
`endif
                end
            end
            StRun: begin
                if (core_reset) begin
                    state_d = StIdle;
                end else begin
                    if (cycle_q != 32'hFFFF_FFFF) cycle_d = cycle_q + 32'd1;
                    if (hit_pass) begin
                        state_d = StPass;
                        pass_d  = 1'b1;
                        done_d  = 1'b1;
                    end else if (hit_odd) begin
                        state_d     = StFail;
                        fail_d      = 1'b1;
                        fail_code_d = wr.wr_data[32:1];
                        done_d      = 1'b1;
                    end else if (wd_fire) begin
                        state_d     = StTmo;
                        fail_d      = 1'b1;
                        tmo_d       = 1'b1;
                        fail_code_d = '0;
                        done_d      = 1'b1;
                    end
`ifdef TOHOST_SYSCALL_COUNT_EN
                    if (hit && !wr.wr_data[0] && (wr.wr_data != '0)) begin
                        sys_pulse_d = 1'b1;
                        if (sys_cnt_q != 16'hFFFF) sys_cnt_d = sys_cnt_q + 16'd1;
                    end
`endif
                end
            end
            StPass, StFail, StTmo: begin
                if (status_ack) begin
                    state_d = StIdle;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    tmo_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            tmo_q       <= 1'b0;
            fail_code_q <= '0;
            done_q      <= 1'b0;
            cycle_q     <= '0;
`ifdef TOHOST_SYSCALL_COUNT_EN
            sys_cnt_q   <= '0;
            sys_pulse_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            tmo_q       <= tmo_d;
            fail_code_q <= fail_code_d;
            done_q      <= done_d;
            cycle_q     <= cycle_d;
`ifdef TOHOST_SYSCALL_COUNT_EN
            sys_cnt_q   <= sys_cnt_d;
            sys_pulse_q <= sys_pulse_d;
`endif
        end
    end

    assign pass_status = pass_q;
    assign fail_status = fail_q;
    assign timeout     = tmo_q;
    assign fail_code   = fail_code_q;
    assign done_pulse  = done_q;
    assign cycle_count = cycle_q;
`ifdef TOHOST_SYSCALL_COUNT_EN
    assign syscall_count = sys_cnt_q;
    assign syscall_pulse = sys_pulse_q;
`endif

    a_pass_fail_exclusive: assert property (@(posedge clk) !(pass_q && fail_q));

endmodule
